mgc_serial: RTL and testbench
=============================

Name: mgc_serial

Overview:
- Sequential wide-operand magnitude comparator that sits directly downstream of the 4-bit combinational comparator `mgc` and consumes its AeqB/AgtB/AltB outputs.
- Latches two W-bit operands on a start pulse.
- Feeds them one nibble per cycle, MSB nibble first, into a single `mgc` instance.
- Terminates at the first unequal nibble and reports a registered, one-hot result with a done pulse.

Parameters:
- NIBBLES, 4: number of 4-bit nibbles per operand. Must be ≥ 1.
- W, 4*NIBBLES: operand width. Derived; do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a compare. Sampled only in IDLE.
- a  in  W  operand A. Sampled on the cycle start is accepted.
- b  in  W  operand B. Sampled on the cycle start is accepted.
- busy  out  1  high while a compare is in progress (RUN state).
- done  out  1  one-cycle pulse when the result becomes valid.
- aeqb  out  1  registered result: A == B.
- agtb  out  1  registered result: A > B.
- altb  out  1  registered result: A < B.

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy, done, aeqb, agtb and altb all 0; shift registers and nibble index cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at edge T: load a and b into W-bit shift registers, set idx=0, clear aeqb/agtb/altb to 000, go to RUN.
  - start=0: stay in IDLE, results hold.
- RUN (busy=1):
  - The top nibble of each shift register drives `mgc` A and B.
  - If AgtB or AltB: register agtb/altb accordingly (aeqb=0), go to DONE.
  - Else if AeqB and idx==NIBBLES-1: register aeqb=1, go to DONE.
  - Else: shift both registers left by 4, increment idx, stay in RUN.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE unconditionally.
- Latency:
  - Nibble k (0 = MSB) is compared during cycle T+1+k.
  - done is high in cycle T+2+k, where k is the first differing nibble, or NIBBLES-1 if the operands are equal.
  - Worst case is NIBBLES+1 cycles from the start edge to done.
- Result validity: aeqb/agtb/altb are one-hot from done onward and hold until the next accepted start. They read 000 while busy.
- start is ignored in RUN and DONE; no queuing. a and b may change freely after acceptance.
- Reset mid-RUN: abort immediately to reset values. No done pulse is issued.
- idx width is clog2(NIBBLES), minimum 1 bit.
- NIBBLES=1: RUN always lasts exactly one cycle.
- Outputs are driven from flops only; there is no combinational path from `mgc` to any output.

Decomposition:
- Package mgc_serial_pkg:
  - NIBBLE_W=4.
  - State enum {IDLE, RUN, DONE}, encoded as 2-bit values 0/1/2.
  - Result encoding constants RES_EQ=3'b100, RES_GT=3'b010, RES_LT=3'b001, RES_NONE=3'b000.
- Sub-module: exactly one instance of the existing 4-bit comparator `mgc`, ports A, B, AeqB, AgtB, AltB. There is no other sub-module.
- All sequencing lives in mgc_serial.

Test Plan (NIBBLES=4):
- Reset, then hold start=0 for 3 cycles -> busy=0, done=0, {aeqb,agtb,altb}=000 throughout.
- a=16'h1234, b=16'h1234, start pulse at T -> busy for T+1..T+4, done at T+5 only, aeqb=1, agtb=0, altb=0 held afterwards.
- a=16'h8000, b=16'h7FFF -> first nibble differs, done at T+2, agtb=1. Then a=16'h12A4, b=16'h12B0 -> differs at nibble 2, done at T+4, altb=1.
- a=16'hFFFF, b=16'hFFFE -> done at T+5, agtb=1. a=16'h0000, b=16'h0000 -> done at T+5, aeqb=1.
- Start a=16'h0001, b=16'h0002; at T+2 pulse start with a=16'hF000, b=16'h0000 -> second start ignored. Result is altb=1 at T+5, followed by exactly one done pulse.
- Start a=16'h1111, b=16'h1112; drop rst_n asynchronously at mid-cycle T+2 -> all outputs 0 immediately and no done pulse. After release, a new start with a=16'h0010, b=16'h0001 -> agtb=1 at T'+4.

Source files
------------

// File: rtl/mgc_serial_pkg.sv
// ============================================================================
// mgc_serial_pkg : shared types and constants for the serial magnitude compare
// Rev 1.0
// ============================================================================
`default_nettype none

package mgc_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result bits are ordered {aeqb, agtb, altb}
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

endpackage

`default_nettype wire

// File: rtl/mgc.sv
// ============================================================================
// mgc : 4-bit combinational magnitude comparator
// Rev 1.0
// ============================================================================
`default_nettype none

module mgc (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       AeqB,
  output logic       AgtB,
  output logic       AltB
);

  assign AeqB = (A == B);
  assign AgtB = (A > B);
  assign AltB = (A < B);

endmodule

`default_nettype wire

// File: rtl/mgc_serial.sv
// ============================================================================
// mgc_serial : wide-operand comparator, one nibble per cycle MSB first via mgc
// Rev 1.0
// ============================================================================
`default_nettype none

module mgc_serial
  import mgc_serial_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         aeqb,
  output logic         agtb,
  output logic         altb
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state;
  logic [W-1:0]        sh_a;
  logic [W-1:0]        sh_b;
  logic [IDX_W-1:0]    idx;
  logic [2:0]          res;
  logic                busy_q;
  logic                done_q;

  logic                nib_eq;
  logic                nib_gt;
  logic                nib_lt;

  mgc u_mgc (
    .A    (sh_a[W-1 -: NIBBLE_W]),
    .B    (sh_b[W-1 -: NIBBLE_W]),
    .AeqB (nib_eq),
    .AgtB (nib_gt),
    .AltB (nib_lt)
  );

  // busy/done are kept as their own flops so every output comes straight from a register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      idx    <= '0;
      res    <= RES_NONE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a   <= a;
            sh_b   <= b;
            idx    <= '0;
            res    <= RES_NONE;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (nib_gt || nib_lt) begin
            res    <= nib_gt ? RES_GT : RES_LT;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else if (nib_eq && (idx == LAST_IDX)) begin
            res    <= RES_EQ;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            sh_a <= sh_a << NIBBLE_W;
            sh_b <= sh_b << NIBBLE_W;
            idx  <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign {aeqb, agtb, altb} = res;

endmodule

`default_nettype wire

// File: tb/tb_mgc_serial.sv
// ============================================================================
// tb_mgc_serial : directed scoreboard bench for mgc_serial (NIBBLES=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mgc_serial;

  localparam int NIB = 4;
  localparam int WD  = 4 * NIB;

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [WD-1:0] a;
  logic [WD-1:0] b;
  logic          busy;
  logic          done;
  logic          aeqb;
  logic          agtb;
  logic          altb;

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;
  logic [2:0] last_res;

  mgc_serial #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .aeqb  (aeqb),
    .agtb  (agtb),
    .altb  (altb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every done pulse and polices outputs otherwise
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done at cyc %0d: got done=1, required no done", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if ({aeqb, agtb, altb} !== e.res) begin
            errors++;
            $display("FAIL result: got %b, required %b", {aeqb, agtb, altb}, e.res);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL done_cycle: got %0d, required %0d", cyc, e.cyc);
          end
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: got %b, required 0", busy);
          end
          last_res = e.res;
        end
      end else if (busy) begin
        checks++;
        if ({aeqb, agtb, altb} !== 3'b000) begin
          errors++;
          $display("FAIL result_while_busy: got %b, required 000", {aeqb, agtb, altb});
        end
        last_res = 3'b000;
      end else begin
        checks++;
        if ({aeqb, agtb, altb} !== last_res) begin
          errors++;
          $display("FAIL result_hold: got %b, required %b", {aeqb, agtb, altb}, last_res);
        end
      end
    end else begin
      last_res = 3'b000;
    end
  end

  task automatic check_idle_zero(input string name);
    checks++;
    if ({busy, done, aeqb, agtb, altb} !== 5'b0) begin
      errors++;
      $display("FAIL %s: got busy/done/res=%b, required 00000", name, {busy, done, aeqb, agtb, altb});
    end
  endtask

  // Issue one start; lat = cycles from the start edge to the cycle done is sampled
  task automatic issue(input logic [WD-1:0] va, input logic [WD-1:0] vb,
                       input logic [2:0] res, input int lat, input bit expect_it);
    exp_t e;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_it) begin
      e.res = res;
      e.cyc = cyc + lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d pending results, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; last_res = 3'b000;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset_state");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_zero("idle_no_start");
    end

    issue(16'h1234, 16'h1234, EQ, 4, 1'b1); wait_idle("eq_1234");
    issue(16'h8000, 16'h7FFF, GT, 1, 1'b1); wait_idle("gt_msb");
    issue(16'h12A4, 16'h12B0, LT, 3, 1'b1); wait_idle("lt_nib2");
    issue(16'hFFFF, 16'hFFFE, GT, 4, 1'b1); wait_idle("gt_lsb");
    issue(16'h0000, 16'h0000, EQ, 4, 1'b1); wait_idle("eq_zero");

    // Second start during RUN must be ignored
    issue(16'h0001, 16'h0002, LT, 4, 1'b1);
    @(negedge clk);
    a = 16'hF000; b = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ignored_start");

    // Asynchronous reset in the middle of a compare
    issue(16'h1111, 16'h1112, LT, 0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_zero("async_reset_abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(16'h0010, 16'h0001, GT, 3, 1'b1); wait_idle("after_reset");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
